// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared types and elaboration helpers for the pipelined carry-lookahead
// adder/subtractor (cla_adder_pipe) and its CLA group cell (cla_block).
//
// Contents:
//   alu_mode_e     operating mode decoded from the 'sub' input
//   stage_flags_t  per-stage control/flag bundle carried in the pipeline
//   n_groups()     number of CLA groups covering a given bit width
//   seg_width()    bits handled by each pipeline stage
// -----------------------------------------------------------------------------
package cla_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } alu_mode_e;

  // Control part of a pipeline stage payload. The wide operand/sum fields
  // depend on the WIDTH parameter, so they are added by the top module.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
    logic zero;
  } stage_flags_t;

  function automatic int unsigned n_groups(input int unsigned width,
                                           input int unsigned block);
    return width / block;
  endfunction

  function automatic int unsigned seg_width(input int unsigned width,
                                            input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_block.sv
// -----------------------------------------------------------------------------
// cla_block
// Combinational BLOCK-bit carry-lookahead group.
//
// Ports:
//   a_i, b_i  [BLOCK]  operand bits of this group
//   c_i       1        carry into the group
//   s_o       [BLOCK]  sum bits
//   g_o       1        group generate (carry out regardless of c_i)
//   p_o       1        group propagate (carry out equals c_i)
// -----------------------------------------------------------------------------
module cla_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             c_i,
  output logic [BLOCK-1:0] s_o,
  output logic             g_o,
  output logic             p_o
);

  logic [BLOCK-1:0] gen;
  logic [BLOCK-1:0] prop;
  logic [BLOCK-1:0] carryIn;
  logic             carryAcc;
  logic             grpAcc;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Each bit carry is expanded from c_i and the lower generate/propagate
  // terms, so no bit waits on the carry of its neighbour.
  always_comb begin
    carryIn  = '0;
    carryAcc = 1'b0;
    for (int i = 0; i < int'(BLOCK); i++) begin
      carryAcc = c_i;
      for (int j = 0; j < i; j++) begin
        carryAcc = gen[j] | (prop[j] & carryAcc);
      end
      carryIn[i] = carryAcc;
    end
  end

  // Group generate ignores c_i; group propagate is the AND of all bit propagates.
  always_comb begin
    grpAcc = 1'b0;
    for (int j = 0; j < int'(BLOCK); j++) begin
      grpAcc = gen[j] | (prop[j] & grpAcc);
    end
  end

  assign s_o = prop ^ carryIn;
  assign g_o = grpAcc;
  assign p_o = &prop;

endmodule

// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Stage s adds bits [s*WIDTH/STAGES +: WIDTH/STAGES] and hands its segment
// carry to stage s+1; the last stage also produces the overflow/zero flags.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand beat handshake
//   a, b     [WIDTH]      operands
//   cin                   carry in (ignored when sub=1)
//   sub                   0: a+b+cin   1: a-b
//   out_valid / out_ready result beat handshake
//   sum      [WIDTH]      result
//   cout                  carry out (sub: 1 = no borrow)
//   ovf                   signed overflow
//   zero                  sum == 0
// -----------------------------------------------------------------------------
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SW = seg_width(WIDTH, STAGES);
  localparam int unsigned NG = n_groups(SW, BLOCK);

  if (BLOCK < 1 || WIDTH % (STAGES * BLOCK) != 0) begin : g_chk_div
    $error("cla_adder_pipe: WIDTH must be a multiple of STAGES*BLOCK");
  end
  if (STAGES < 1 || STAGES > WIDTH / BLOCK) begin : g_chk_stages
    $error("cla_adder_pipe: STAGES must lie in 1..WIDTH/BLOCK");
  end

  // Full operands travel with the beat so later stages can pick their
  // segment; finished low sum bits accumulate in 'sum'.
  typedef struct packed {
    stage_flags_t     flags;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bEff;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t             stage_q [STAGES];
  stage_t             stage_d [STAGES];
  stage_t             inBeat;
  logic  [STAGES-1:0] stageReady;
  alu_mode_e          mode;

  assign mode = alu_mode_e'(sub);

  // Subtraction becomes a + ~b + 1, so the seed carry replaces cin.
  always_comb begin
    inBeat             = '0;
    inBeat.flags.valid = in_valid;
    inBeat.flags.carry = (mode == SUB) ? 1'b1 : cin;
    inBeat.a           = a;
    inBeat.bEff        = (mode == SUB) ? ~b : b;
  end

  for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
    stage_t        src;
    stage_t        nxt;
    logic [SW-1:0] segA;
    logic [SW-1:0] segB;
    logic [SW-1:0] segS;
    logic [NG-1:0] grpG;
    logic [NG-1:0] grpP;
    logic [NG:0]   grpC;
    logic          lookAcc;

    if (s == 0) begin : g_first
      assign src = inBeat;
    end else begin : g_next
      assign src = stage_q[s-1];
    end

    assign segA = src.a[s*SW +: SW];
    assign segB = src.bEff[s*SW +: SW];

    for (genvar g = 0; g < int'(NG); g++) begin : g_grp
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a_i (segA[g*BLOCK +: BLOCK]),
        .b_i (segB[g*BLOCK +: BLOCK]),
        .c_i (grpC[g]),
        .s_o (segS[g*BLOCK +: BLOCK]),
        .g_o (grpG[g]),
        .p_o (grpP[g])
      );
    end

    // Group carries are expanded from the segment carry-in and the group
    // generate/propagate terms rather than rippled group to group.
    always_comb begin
      grpC    = '0;
      lookAcc = 1'b0;
      grpC[0] = src.flags.carry;
      for (int g = 1; g <= int'(NG); g++) begin
        lookAcc = src.flags.carry;
        for (int j = 0; j < g; j++) begin
          lookAcc = grpG[j] | (grpP[j] & lookAcc);
        end
        grpC[g] = lookAcc;
      end
    end

    // Carry into the MSB is recovered from the MSB sum bit, so the overflow
    // flag needs no extra carry wire out of the last group.
    always_comb begin
      nxt                  = src;
      nxt.sum[s*SW +: SW]  = segS;
      nxt.flags.carry      = grpC[NG];
      nxt.flags.ovf        = 1'b0;
      nxt.flags.zero       = 1'b0;
      if (s == int'(STAGES) - 1) begin
        nxt.flags.ovf  = src.a[WIDTH-1] ^ src.bEff[WIDTH-1] ^ segS[SW-1] ^ grpC[NG];
        nxt.flags.zero = (nxt.sum == '0);
      end
    end

    assign stage_d[s] = nxt;
  end

  // A stage can load when it is empty or its content moves on this edge;
  // the chain lets a full pipe accept while it drains.
  always_comb begin
    stageReady             = '0;
    stageReady[STAGES-1]   = !stage_q[STAGES-1].flags.valid || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      stageReady[k] = !stage_q[k].flags.valid || stageReady[k+1];
    end
  end

  // Stage registers; a bubble from upstream clears the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (stageReady[k]) begin
          stage_q[k] <= stage_d[k];
        end
      end
    end
  end

  assign in_ready  = stageReady[0];
  assign out_valid = stage_q[STAGES-1].flags.valid;
  assign sum       = stage_q[STAGES-1].sum;
  assign cout      = stage_q[STAGES-1].flags.carry;
  assign ovf       = stage_q[STAGES-1].flags.ovf;
  assign zero      = stage_q[STAGES-1].flags.zero;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_adder_pipe
// Self-checking bench for cla_adder_pipe (WIDTH=32, BLOCK=4, STAGES=2).
// -----------------------------------------------------------------------------
module tb_cla_adder_pipe;

  localparam int W   = 32;
  localparam int STG = 2;
  localparam int NRAND = 10000;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         ze;
  } result_t;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ci;
    logic         sb;
    result_t      exp;
  } vector_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(STG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Reference: plain unsigned and signed arithmetic at 64 bits.
  function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic ci, input logic sb);
    result_t      r;
    logic [W-1:0] yEff;
    logic         c0;
    logic [63:0]  u;
    longint       sgn;
    yEff = sb ? ~y : y;
    c0   = sb ? 1'b1 : ci;
    u    = {32'b0, x} + {32'b0, yEff} + {63'b0, c0};
    sgn  = $signed(x) + $signed(yEff) + $signed({1'b0, c0});
    r.s  = u[W-1:0];
    r.co = u[W];
    r.ov = (sgn > 64'sd2147483647) || (sgn < -64'sd2147483648);
    r.ze = (r.s == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drives one beat with out_ready high and returns the result and latency.
  task automatic run_beat(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb,
                          output result_t r, output int lat, output bit timedOut);
    int waitCnt;
    timedOut = 1'b0;
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      @(negedge clk); #1;
      waitCnt++;
    end
    if (!in_ready) timedOut = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) timedOut = 1'b1;
    r = {sum, cout, ovf, zero};
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    else passCount++;
    checkCount++;
    if ({sum, cout, ovf, zero} !== '0)
      $display("[TB] FAIL reset_regs: got sum=%h cout=%b ovf=%b zero=%b want all 0", sum, cout, ovf, zero);
    else passCount++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    else passCount++;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_release_out_valid: got %b want 0", out_valid);
    else passCount++;
  endtask

  task automatic test_add();
    vector_t vecs[5];
    result_t r;
    int      lat;
    bit      to;
    vecs[0] = {32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = {32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = {32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = {32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[4] = {32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_beat(vecs[i].x, vecs[i].y, vecs[i].ci, vecs[i].sb, r, lat, to);
      checkCount++;
      if (to || lat != STG) $display("[TB] FAIL add_latency[%0d]: got %0d timeout=%0b want %0d", i, lat, to, STG);
      else passCount++;
      checkCount++;
      if (r !== vecs[i].exp) $display("[TB] FAIL add_result[%0d]: got %h want %h", i, r, vecs[i].exp);
      else passCount++;
    end
  endtask

  task automatic test_sub();
    vector_t vecs[5];
    result_t r;
    int      lat;
    bit      to;
    vecs[0] = {32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[1] = {32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[2] = {32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[3] = {32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = {32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_beat(vecs[i].x, vecs[i].y, vecs[i].ci, vecs[i].sb, r, lat, to);
      checkCount++;
      if (to || lat != STG) $display("[TB] FAIL sub_latency[%0d]: got %0d timeout=%0b want %0d", i, lat, to, STG);
      else passCount++;
      checkCount++;
      if (r !== vecs[i].exp) $display("[TB] FAIL sub_result[%0d]: got %h want %h", i, r, vecs[i].exp);
      else passCount++;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    logic         sbs[4];
    result_t      q[$];
    result_t      exp;
    int           accepted = 0;
    int           fellAt = -1;
    int           got = 0;
    int           gaps = 0;
    bit           started = 1'b0;
    bit           take;
    for (int i = 0; i < 4; i++) begin
      xs[i] = $urandom; ys[i] = $urandom; sbs[i] = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    a = xs[0]; b = ys[0]; sub = sbs[0]; cin = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (!in_ready && fellAt < 0) fellAt = accepted;
      take = in_valid && in_ready;
      if (take) begin q.push_back(model(a, b, cin, sub)); accepted++; end
      @(posedge clk); #1;
      if (take) begin
        if (accepted < 4) begin a = xs[accepted]; b = ys[accepted]; sub = sbs[accepted]; end
        else in_valid = 1'b0;
      end
    end
    checkCount++;
    if (fellAt != 2) $display("[TB] FAIL bp_ready_fall: in_ready fell after %0d accepts want 2", fellAt);
    else passCount++;
    checkCount++;
    if (accepted != 2) $display("[TB] FAIL bp_capacity: accepted %0d while stalled want 2", accepted);
    else passCount++;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      if (started && !out_valid) gaps++;
      if (out_valid && out_ready) begin
        started = 1'b1;
        checkCount++;
        if (q.size() == 0) begin
          $display("[TB] FAIL bp_order[%0d]: got %h with nothing expected", got, {sum, cout, ovf, zero});
        end else begin
          exp = q.pop_front();
          if ({sum, cout, ovf, zero} !== exp)
            $display("[TB] FAIL bp_order[%0d]: got %h want %h", got, {sum, cout, ovf, zero}, exp);
          else passCount++;
        end
        got++;
      end
      take = in_valid && in_ready;
      if (take) begin q.push_back(model(a, b, cin, sub)); accepted++; end
      @(posedge clk); #1;
      if (take) begin
        if (accepted < 4) begin a = xs[accepted]; b = ys[accepted]; sub = sbs[accepted]; end
        else in_valid = 1'b0;
      end
    end
    checkCount++;
    if (got != 4) $display("[TB] FAIL bp_count: got %0d results want 4", got);
    else passCount++;
    checkCount++;
    if (gaps != 0) $display("[TB] FAIL bp_gaps: got %0d bubbles want 0", gaps);
    else passCount++;
  endtask

  task automatic test_reset_flush();
    int           stale = 0;
    result_t      r;
    result_t      exp;
    int           lat;
    bit           to;
    logic [W-1:0] x;
    logic [W-1:0] y;
    @(posedge clk); #1;
    out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
    a = $urandom; b = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    a = $urandom; b = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkCount++;
    if (out_valid !== 1'b1) $display("[TB] FAIL flush_inflight: out_valid got %b want 1", out_valid);
    else passCount++;
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL flush_out_valid: got %b want 0", out_valid);
    else passCount++;
    checkCount++;
    if ({sum, cout, ovf, zero} !== '0)
      $display("[TB] FAIL flush_regs: got %h want 0", {sum, cout, ovf, zero});
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkCount++;
    if (stale != 0) $display("[TB] FAIL flush_stale: got %0d stale beats want 0", stale);
    else passCount++;
    x = $urandom; y = $urandom;
    exp = model(x, y, 1'b1, 1'b0);
    run_beat(x, y, 1'b1, 1'b0, r, lat, to);
    checkCount++;
    if (to || lat != STG) $display("[TB] FAIL flush_latency: got %0d timeout=%0b want %0d", lat, to, STG);
    else passCount++;
    checkCount++;
    if (r !== exp) $display("[TB] FAIL flush_result: got %h want %h", r, exp);
    else passCount++;
  endtask

  task automatic test_random();
    result_t q[$];
    result_t exp;
    result_t heldRes;
    bit      holdPending = 1'b0;
    bit      inTake;
    bit      outTake;
    int      sent = 0;
    int      received = 0;
    int      cyc = 0;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    while (received < NRAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (holdPending) begin
        checkCount++;
        if (!out_valid || {sum, cout, ovf, zero} !== heldRes)
          $display("[TB] FAIL rand_hold: got valid=%b %h want valid=1 %h", out_valid, {sum, cout, ovf, zero}, heldRes);
        else passCount++;
      end
      inTake  = in_valid && in_ready;
      outTake = out_valid && out_ready;
      if (outTake) begin
        checkCount++;
        if (q.size() == 0) begin
          $display("[TB] FAIL rand_result[%0d]: got %h with nothing expected", received, {sum, cout, ovf, zero});
        end else begin
          exp = q.pop_front();
          if ({sum, cout, ovf, zero} !== exp)
            $display("[TB] FAIL rand_result[%0d]: got %h want %h", received, {sum, cout, ovf, zero}, exp);
          else passCount++;
        end
        received++;
      end
      holdPending = out_valid && !out_ready;
      heldRes     = {sum, cout, ovf, zero};
      if (inTake) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
      @(posedge clk); #1;
      if (inTake || !in_valid) begin
        if (sent < NRAND) begin
          in_valid = ($urandom_range(0, 3) != 0);
          a   = pick_operand();
          b   = pick_operand();
          cin = 1'($urandom_range(0, 1));
          sub = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    checkCount++;
    if (received != NRAND) $display("[TB] FAIL rand_count: got %0d results want %0d", received, NRAND);
    else passCount++;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_flush();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
